uart_sender: RTL and testbench

UART_SENDER -- requirements
Module: uart_sender

---
 rtl/uart_sender.sv | 131 +++++++++++++
 tb/tb_uart_sender.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_sender.sv
// Buffered 8N1 UART transmitter: a small power-of-two FIFO feeds a
// start/data/stop framing FSM that emits back-to-back frames with no idle gap.
module uart_sender #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic [4:0] fifo_count
);

  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] BAUD_TC = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                         state;
  logic [15:0]                    baud;
  logic [2:0]                     bit_idx;
  logic [7:0]                     shift;
  logic [FIFO_DEPTH-1:0][7:0]     mem;
  logic [PW-1:0]                  wr_ptr;
  logic [PW-1:0]                  rd_ptr;
  logic [4:0]                     count;

  logic baud_tc;
  logic push;
  logic pop;

  // Ready comes from the registered count only, so a full FIFO never accepts
  // on the same edge that it pops.
  assign tx_ready   = (count < DEPTH_C);
  assign fifo_count = count;
  assign tx_busy    = (state != IDLE) || (count != 5'd0);

  assign baud_tc = (baud == BAUD_TC);
  assign push    = tx_valid && tx_ready;
  assign pop     = (count != 5'd0) &&
                   ((state == IDLE) || ((state == STOP) && baud_tc));

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {4'd0, push} - {4'd0, pop};
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      baud    <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          txd  <= 1'b1;
          baud <= 16'd0;
          if (pop) begin
            shift <= mem[rd_ptr];
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_tc) begin
            baud    <= 16'd0;
            txd     <= shift[0];
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud <= 16'd0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd     <= shift[bit_idx + 3'd1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        STOP: begin
          if (baud_tc) begin
            baud <= 16'd0;
            // Chain straight into the next start bit when data is waiting.
            if (pop) begin
              shift <= mem[rd_ptr];
              txd   <= 1'b0;
              state <= START;
            end else begin
              txd   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          baud  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// Randomized bench for uart_sender: a cycle-level line model plus a mid-bit
// UART receiver that pops expected bytes from a scoreboard queue.
module tb_uart_sender;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       tx_busy;
  logic [4:0] fifo_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb[$];

  uart_sender #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line value at cycle idx of a frame: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    logic [9:0] w;
    w = {1'b1, b, 1'b0};
    return w[idx];
  endfunction

  // Cycle model: a byte waits in a queue; a frame starts on the first edge
  // where the line is free and the queue was non-empty before that edge.
  logic [7:0] mq[$];
  bit         in_frame = 1'b0;
  int         fcyc = 0;
  logic [7:0] fbyte;
  bit         push_pend = 1'b0;
  logic [7:0] push_data;

  always @(negedge sysclk) begin : line_model
    int   cnt_pre;
    logic exp_txd;
    if (!reset) begin
      mq.delete();
      in_frame  = 1'b0;
      fcyc      = 0;
      push_pend = 1'b0;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd1);
    end else begin
      cnt_pre = mq.size();
      if (in_frame) begin
        fcyc++;
        if (fcyc == FRAME) in_frame = 1'b0;
      end
      if (!in_frame && cnt_pre > 0) begin
        fbyte    = mq.pop_front();
        in_frame = 1'b1;
        fcyc     = 0;
      end
      if (push_pend) mq.push_back(push_data);
      exp_txd = in_frame ? frame_bit(fbyte, fcyc / CPB) : 1'b1;
      check("txd", 32'(txd), 32'(exp_txd));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("tx_ready", 32'(tx_ready), 32'(mq.size() < DEPTH));
      check("tx_busy", 32'(tx_busy), 32'(in_frame || mq.size() != 0));
      push_pend = (tx_valid === 1'b1) && (mq.size() < DEPTH);
      push_data = tx_data;
    end
  end

  // Receiver: samples mid-bit and compares each decoded byte with the scoreboard.
  bit         rx_on = 1'b0;
  int         rcyc = 0;
  logic [7:0] rbyte;

  always @(negedge sysclk) begin : receiver
    int k;
    if (!reset) begin
      rx_on = 1'b0;
      sb.delete();
    end else if (!rx_on) begin
      if (txd === 1'b0) begin
        rx_on = 1'b1;
        rcyc  = 0;
      end
    end else begin
      rcyc++;
      if (rcyc % CPB == CPB / 2) begin
        k = rcyc / CPB;
        if (k == 0) check("rx_start", 32'(txd), 32'd0);
        else if (k <= 8) rbyte[k-1] = txd;
        else begin
          check("rx_stop", 32'(txd), 32'd1);
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_extra: got byte %0h expected no frame", rbyte);
          end else begin
            check("rx_byte", 32'(rbyte), 32'(sb.pop_front()));
          end
          rx_on = 1'b0;
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    int  n;
    bit  acc;
    n        = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    forever begin
      @(negedge sysclk);
      acc = tx_ready;
      @(posedge sysclk);
      if (acc) break;
      n++;
      if (n > 20 * FRAME) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: byte %0h never accepted", b);
        #1 tx_valid = 1'b0;
        return;
      end
    end
    sb.push_back(b);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge sysclk);
    while (tx_busy !== 1'b0 && n < FRAME * (DEPTH + 3)) begin
      @(negedge sysclk);
      n++;
    end
    check("drain", 32'(tx_busy), 32'd0);
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #2 reset = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 reset = 1'b1;
    @(posedge sysclk);
    #1;

    send(8'h69);
    wait_idle();

    send(8'h46); send(8'h1E); send(8'h69); send(8'hB9);
    wait_idle();

    // Holding valid through a full FIFO.
    send(8'h01); send(8'h23); send(8'h45); send(8'h67); send(8'h89); send(8'hAB);
    wait_idle();

    // Abort mid-frame during data bit 3 with a second byte still queued.
    send(8'h96);
    send(8'h11);
    repeat (4 * CPB + 1) @(posedge sysclk);
    #1 reset = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 reset = 1'b1;
    @(posedge sysclk);
    #1;
    send(8'h1E);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 60) == 0 ? 0 : $urandom_range(0, 3 * FRAME / 2)) @(posedge sysclk);
      #1;
      send(b);
      if ($urandom_range(0, 7) == 0) wait_idle();
    end
    wait_idle();

    repeat (2) @(posedge sysclk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("model_empty", 32'(mq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
